// File: rtl/up_down_counter_pkg.sv
// Shared types for the up_down_counter slice: decode of the two step enables.
// Saturation versus wrap is selected elsewhere by the UP_DOWN_COUNTER_SAT_EN macro.
package up_down_counter_pkg;

    // Encoded as {up, dn} so a direct cast from the enable pair selects the step.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_DN   = 2'b01,
        STEP_UP   = 2'b10,
        STEP_BOTH = 2'b11
    } step_sel_e;

endpackage

// File: rtl/up_down_counter_signed_add_ovf.sv
// Combinational signed three-operand adder with out-of-range detection.
// Wraps by default; clamps to MAX/MIN when UP_DOWN_COUNTER_SAT_EN is defined.
module signed_add_ovf #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] val_i,
    input  logic signed [WIDTH-1:0] d0_i,
    input  logic signed [WIDTH-1:0] d1_i,
    output logic signed [WIDTH-1:0] res_o,
    output logic                    oor_o
);

    // Two guard bits hold the exact sum of three WIDTH-bit signed operands.
    localparam int EW = WIDTH + 2;

    localparam logic signed [EW-1:0]    EXT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0]    EXT_MIN = {3'b111, {(WIDTH-1){1'b0}}};
`ifdef UP_DOWN_COUNTER_SAT_EN
    localparam logic signed [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic signed [EW-1:0] val_x;
    logic signed [EW-1:0] d0_x;
    logic signed [EW-1:0] d1_x;
    logic signed [EW-1:0] ext;

    assign val_x = $signed({{2{val_i[WIDTH-1]}}, val_i});
    assign d0_x  = $signed({{2{d0_i[WIDTH-1]}},  d0_i});
    assign d1_x  = $signed({{2{d1_i[WIDTH-1]}},  d1_i});
    assign ext   = val_x + d0_x + d1_x;

    assign oor_o = (ext > EXT_MAX) || (ext < EXT_MIN);

`ifdef UP_DOWN_COUNTER_SAT_EN
    assign res_o = oor_o ? (ext[EW-1] ? Q_MIN : Q_MAX) : ext[WIDTH-1:0];
`else
    assign res_o = ext[WIDTH-1:0];
`endif

endmodule

// File: rtl/up_down_counter.sv
// Registered signed up/down accumulator with a one-cycle overflow flag.
// Define UP_DOWN_COUNTER_SAT_EN to saturate instead of wrapping on overflow.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    up,
    input  logic                    dn,
    output logic signed [WIDTH-1:0] q,
    output logic                    overflow
);

    logic signed [WIDTH-1:0] cnt_q;
    logic signed [WIDTH-1:0] cnt_d;
    logic signed [WIDTH-1:0] step_a;
    logic signed [WIDTH-1:0] step_b;
    logic                    ovf_q;
    logic                    ovf_d;
    step_sel_e               sel;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sel    = step_sel_e'({up, dn});
        step_a = '0;
        step_b = '0;
        unique case (sel)
            STEP_HOLD: ;
            STEP_UP:   step_a = a;
            STEP_DN:   step_b = b;
            STEP_BOTH: begin
                step_a = a;
                step_b = b;
            end
        endcase
    end

    // Hold falls out naturally: zero deltas keep q and give oor=0.
    signed_add_ovf #(
        .WIDTH (WIDTH)
    ) u_add (
        .val_i (cnt_q),
        .d0_i  (step_a),
        .d1_i  (step_b),
        .res_o (cnt_d),
        .oor_o (ovf_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q        = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter (WIDTH=8).
// Expectations follow UP_DOWN_COUNTER_SAT_EN when it is defined for the build.
module tb_up_down_counter;

    logic              clk;
    logic              rst;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic              up;
    logic              dn;
    logic signed [7:0] q;
    logic              overflow;

    int n_cmp;
    int n_bad;

    up_down_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .up       (up),
        .dn       (dn),
        .q        (q),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare q and overflow 1 ns later.
    task automatic tick_chk(input string tag, input int exp_q, input int exp_o);
        @(posedge clk);
        #1;
        check({tag, ".q"}, int'(q), exp_q);
        check({tag, ".ovf"}, int'(overflow), exp_o);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        up  = 1'b1;
        tick_chk("rst", 0, 0);
        rst = 1'b1;
        up  = 1'b0;
        dn  = 1'b0;
    endtask

`ifdef UP_DOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; up = 1'b1; dn = 1'b0; a = 8'sd29; b = -8'sd17;

        // Reset held for two edges with up asserted.
        tick_chk("reset0", 0, 0);
        tick_chk("reset1", 0, 0);
        rst = 1'b1; up = 1'b0;

        // Up count into overflow.
        up = 1'b1;
        tick_chk("up1", 29, 0);
        tick_chk("up2", 58, 0);
        tick_chk("up3", 87, 0);
        tick_chk("up4", 116, 0);
        tick_chk("up_ovf", SAT ? 127 : -111, 1);
        tick_chk("up_after", SAT ? 127 : -82, SAT ? 1 : 0);
        do_reset();

        // Down count into underflow.
        dn = 1'b1;
        for (int i = 1; i <= 7; i++) tick_chk($sformatf("dn%0d", i), -17 * i, 0);
        tick_chk("dn_ovf", SAT ? -128 : 120, 1);
        do_reset();

        // Both enables: combined step of +12.
        up = 1'b1; dn = 1'b1;
        for (int i = 1; i <= 10; i++) tick_chk($sformatf("both%0d", i), 12 * i, 0);
        tick_chk("both_ovf", SAT ? 127 : -124, 1);
        do_reset();

        // Hold, then reset in mid-run.
        up = 1'b1;
        tick_chk("pre_hold1", 29, 0);
        tick_chk("pre_hold2", 58, 0);
        up = 1'b0;
        for (int i = 1; i <= 3; i++) tick_chk($sformatf("hold%0d", i), 58, 0);
        rst = 1'b0; up = 1'b1;
        tick_chk("mid_rst", 0, 0);
        rst = 1'b1;

        // Zero step with enable set behaves as hold.
        a = 8'sd0;
        tick_chk("a_zero", 0, 0);
        up = 1'b0; dn = 1'b1; b = 8'sd0;
        tick_chk("b_zero", 0, 0);

        // Positive edge: 127 + 1.
        dn = 1'b0; up = 1'b1; a = 8'sd127;
        tick_chk("to_max", 127, 0);
        a = 8'sd1;
        tick_chk("max_p1", SAT ? 127 : -128, 1);
        up = 1'b0;
        tick_chk("ovf_clr_hold", SAT ? 127 : -128, 0);
        do_reset();

        // Negative edge: -128 + (-1).
        up = 1'b1; a = -8'sd128;
        tick_chk("to_min", -128, 0);
        up = 1'b0; dn = 1'b1; b = -8'sd1;
        tick_chk("min_m1", SAT ? -128 : 127, 1);

        // Inputs changed between edges are ignored; only the edge value matters.
        do_reset();
        up = 1'b1; a = 8'sd100;
        #3 a = 8'sd5;
        tick_chk("sample_edge", 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
